// File: rtl/cache_slot_releaser.sv
// Return-path free-slot mask keeper: queues released slot indices, applies allocator claims,
// flags double-free / bad-index / bad-alloc. Optional macro CACHE_REL_BYPASS_EN: empty-queue releases skip the queue.
module cache_slot_releaser #(
  parameter int SLOTS = 20,
  parameter int IDX_W = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rel_valid,
  output logic             rel_ready,
  input  logic [IDX_W-1:0] rel_idx,
  input  logic             alloc_valid,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic             flush_req,
  output logic [SLOTS-1:0] bit_mask,
  output logic [IDX_W:0]   free_count,
  output logic             busy,
  output logic             err_double_free,
  output logic             err_bad_idx,
  output logic             err_bad_alloc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] SLOTS_LIM = (IDX_W+1)'(SLOTS);

  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_next;

  logic [IDX_W-1:0] fifo [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_next;
  logic [SLOTS-1:0] mask_next;
  logic [IDX_W:0]   count_ones;
  logic empty, full, active, push, pop, byp, enq, rel_bad, alloc_bad, rel_apply;
  logic [IDX_W-1:0] rel_apply_idx;
  logic dfree_set, bad_idx_set, bad_alloc_set;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign active    = (state == IDLE) && !flush_req;
  assign rel_ready = rst_n && !full && active;
  assign push      = rel_valid && rel_ready;
  assign rel_bad   = {1'b0, rel_idx} >= SLOTS_LIM;
  assign alloc_bad = {1'b0, alloc_idx} >= SLOTS_LIM;
  assign pop       = active && !empty;
`ifdef CACHE_REL_BYPASS_EN
  assign byp       = active && empty && push && !rel_bad;
`else
  assign byp       = 1'b0;
`endif
  assign enq           = push && !rel_bad && !byp;
  assign rel_apply     = pop || byp;
  assign rel_apply_idx = pop ? fifo[rd_ptr] : rel_idx;
  assign busy          = !empty || (state == FLUSH);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (flush_req) state_next = FLUSH;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Release is applied before the claim, so a same-index pair ends with the bit cleared.
  always_comb begin
    mask_next     = bit_mask;
    dfree_set     = 1'b0;
    bad_idx_set   = 1'b0;
    bad_alloc_set = 1'b0;
    if (state == IDLE) begin
      if (flush_req) begin
        mask_next = '1;
      end else begin
        if (push && rel_bad) bad_idx_set = 1'b1;
        if (rel_apply) begin
          if (bit_mask[rel_apply_idx]) dfree_set = 1'b1;
          else mask_next[rel_apply_idx] = 1'b1;
        end
        if (alloc_valid) begin
          if (alloc_bad)
            bad_idx_set = 1'b1;
          else if (bit_mask[alloc_idx] || (rel_apply && rel_apply_idx == alloc_idx))
            mask_next[alloc_idx] = 1'b0;
          else
            bad_alloc_set = 1'b1;
        end
      end
    end
  end

  always_comb begin
    count_ones = '0;
    for (int i = 0; i < SLOTS; i++) count_ones = count_ones + (IDX_W+1)'(mask_next[i]);
  end

  always_comb begin
    count_next = count;
    case ({enq, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) fifo[wr_ptr] <= rel_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bit_mask        <= '1;
      free_count      <= SLOTS_LIM;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      err_double_free <= 1'b0;
      err_bad_idx     <= 1'b0;
      err_bad_alloc   <= 1'b0;
    end else begin
      state      <= state_next;
      bit_mask   <= mask_next;
      free_count <= count_ones;
      if (state == IDLE && flush_req) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count_next;
      end
      if (dfree_set)     err_double_free <= 1'b1;
      if (bad_idx_set)   err_bad_idx     <= 1'b1;
      if (bad_alloc_set) err_bad_alloc   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_slot_releaser.sv
// Scoreboard bench for cache_slot_releaser: a queue/bit-vector reference model predicts every
// cycle's outcome; a separate monitor compares the DUT against the predictions.
module tb_cache_slot_releaser;
  localparam int SLOTS = 20;
  localparam int IDX_W = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rel_valid = 1'b0, alloc_valid = 1'b0, flush_req = 1'b0;
  logic [IDX_W-1:0] rel_idx = '0, alloc_idx = '0;
  logic rel_ready, busy, err_double_free, err_bad_idx, err_bad_alloc;
  logic [SLOTS-1:0] bit_mask;
  logic [IDX_W:0] free_count;

  cache_slot_releaser #(.SLOTS(SLOTS), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rel_valid(rel_valid), .rel_ready(rel_ready), .rel_idx(rel_idx),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .flush_req(flush_req),
    .bit_mask(bit_mask), .free_count(free_count), .busy(busy),
    .err_double_free(err_double_free), .err_bad_idx(err_bad_idx), .err_bad_alloc(err_bad_alloc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit ready; bit [SLOTS-1:0] mask; int cnt; bit busy; bit edf; bit ebi; bit eba; int n;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  bit [SLOTS-1:0] m_mask = '1;
  int m_q[$];
  bit m_flush = 1'b0;
  bit m_edf = 1'b0, m_ebi = 1'b0, m_eba = 1'b0;
  int n_items = 0;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(string name, int n, int act, int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s (item %0d): got 0x%0h, expected 0x%0h", name, n, act, req);
    end
  endtask

  // One clock of stimulus; the model predicts ready (pre-edge) and the post-edge state.
  task automatic step(bit rst, bit v, int idx, bit av, int ai, bit fl);
    exp_t e;
    bit ready, byp;
    int rel_done;
    bit [SLOTS-1:0] pre;
    @(negedge clk);
    rst_n = !rst; rel_valid = v; rel_idx = IDX_W'(idx);
    alloc_valid = av; alloc_idx = IDX_W'(ai); flush_req = fl;
    ready = 1'b0;
    if (rst) begin
      m_mask = '1; m_q.delete(); m_flush = 0; m_edf = 0; m_ebi = 0; m_eba = 0;
    end else begin
      ready = (m_q.size() < DEPTH) && !m_flush && !fl;
      if (m_flush) begin
        m_flush = 0;
      end else if (fl) begin
        m_q.delete(); m_mask = '1; m_flush = 1;
      end else begin
        pre = m_mask; rel_done = -1; byp = 0;
        if (m_q.size() > 0) rel_done = m_q.pop_front();
`ifdef CACHE_REL_BYPASS_EN
        else if (v && ready && idx < SLOTS) begin rel_done = idx; byp = 1; end
`endif
        if (rel_done >= 0) begin
          if (pre[rel_done]) m_edf = 1; else m_mask[rel_done] = 1'b1;
        end
        if (av) begin
          if (ai >= SLOTS) m_ebi = 1;
          else if (pre[ai] || rel_done == ai) m_mask[ai] = 1'b0;
          else m_eba = 1;
        end
        if (v && ready) begin
          if (idx >= SLOTS) m_ebi = 1;
          else if (!byp) m_q.push_back(idx);
        end
      end
    end
    e.rst = rst; e.ready = ready; e.mask = m_mask; e.cnt = $countones(m_mask);
    e.busy = (m_q.size() > 0) || m_flush; e.edf = m_edf; e.ebi = m_ebi; e.eba = m_eba;
    e.n = n_items++;
    exp_q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: ready sampled just before the edge, state just after it.
  initial begin
    exp_t e;
    logic r_ready;
    logic [SLOTS-1:0] r_mask_early;
    forever begin
      @(negedge clk);
      #3;
      r_ready = rel_ready;
      r_mask_early = bit_mask;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rel_ready", e.n, int'(r_ready), int'(e.ready));
        if (e.rst) chk("async_rst_mask", e.n, int'(r_mask_early), int'(e.mask));
        chk("bit_mask", e.n, int'(bit_mask), int'(e.mask));
        chk("free_count", e.n, int'(free_count), e.cnt);
        chk("busy", e.n, int'(busy), int'(e.busy));
        chk("err_double_free", e.n, int'(err_double_free), int'(e.edf));
        chk("err_bad_idx", e.n, int'(err_bad_idx), int'(e.ebi));
        chk("err_bad_alloc", e.n, int'(err_bad_alloc), int'(e.eba));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(3);
    // Alloc 2, 3 then release 3
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 1, 3, 0);
    step(0, 1, 3, 0, 0, 0);
    idle(2);
    // Alloc 0..7, release 0..5 back-to-back
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, i, 0);
    for (int i = 0; i < 6; i++) step(0, 1, i, 0, 0, 0);
    idle(3);
    // Double-free and out-of-range release
    step(0, 1, 10, 0, 0, 0);
    idle(1);
    step(0, 1, 25, 0, 0, 0);
    idle(1);
    // Same-edge release/alloc of slot 4, then a bad re-alloc
    step(0, 0, 0, 1, 4, 0);
    step(0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 1, 4, 0);
    step(0, 0, 0, 1, 4, 0);
    idle(1);
    // Flush with releases pending
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 11, 0);
    step(0, 0, 0, 1, 12, 0);
    step(0, 1, 11, 0, 0, 0);
    step(0, 1, 12, 1, 13, 1);
    step(0, 1, 13, 1, 14, 1);
    idle(2);
    // Reset mid-drain
    step(0, 0, 0, 1, 15, 0);
    step(0, 1, 15, 0, 0, 0);
    step(1, 1, 16, 1, 17, 0);
    idle(2);
    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < 60), $urandom_range(0, 22),
           ($urandom_range(0, 99) < 45), $urandom_range(0, 21),
           ($urandom_range(0, 39) == 0));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", -1, exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
